// File: rtl/control_pkg.sv
// Shared encodings for the RV32I-subset main decoder: opcodes, ALU operations,
// immediate formats, status flag positions and the registered control bundle.
package control_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } aluop_e;

    localparam logic [1:0] IMM_I    = 2'b00;
    localparam logic [1:0] IMM_S    = 2'b01;
    localparam logic [1:0] IMM_B    = 2'b10;
    localparam logic [1:0] IMM_NONE = 2'b11;

    localparam int ST_Z = 4;
    localparam int ST_N = 3;
    localparam int ST_C = 2;
    localparam int ST_V = 1;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_R,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH
    } op_class_e;

    typedef struct packed {
        logic       pcsrc;
        logic       alusrc;
        aluop_e     aluop;
        logic       memrw;
        logic       wb;
        logic       regrw;
        logic [1:0] immgen_ctrl;
    } ctrl_t;

    function automatic op_class_e classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return CLS_R;
            OP_IMM:    return CLS_IMM;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            default:   return CLS_NOP;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from funct3, the funct7 alternate bit
// and the opcode class.
module alu_decoder
    import control_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_b30,
    input  op_class_e  op_class,
    output aluop_e     aluop
);

    always_comb begin
        aluop = ALU_ADD;
        case (op_class)
            CLS_R, CLS_IMM: begin
                case (funct3)
                    // ADDI has no SUB form, so bit 30 only matters for register ops here
                    3'b000: aluop = (funct7_b30 && op_class == CLS_R) ? ALU_SUB : ALU_ADD;
                    3'b001: aluop = ALU_SLL;
                    3'b010: aluop = ALU_SLT;
                    3'b011: aluop = ALU_SLTU;
                    3'b100: aluop = ALU_XOR;
                    3'b101: aluop = funct7_b30 ? ALU_SRA : ALU_SRL;
                    3'b110: aluop = ALU_OR;
                    default: aluop = ALU_AND;
                endcase
            end
            CLS_BRANCH: aluop = ALU_SUB;
            default:    aluop = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main decoder: classifies the opcode, resolves branch conditions from the ALU
// flags and registers the full control bundle with one cycle of latency.
module control_unit
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  status,
    input  logic [31:0] instr,
    output logic        pcsrc,
    output logic        alusrc,
    output logic [3:0]  aluop,
    output logic        memrw,
    output logic        wb,
    output logic        regrw,
    output logic [1:0]  immgen_ctrl
);

    op_class_e op_class;
    aluop_e    aluop_dec;
    logic      branch_taken;
    ctrl_t     ctrl_d;
    ctrl_t     ctrl_q;
    logic      unused_bits;

    assign op_class    = classify(instr[6:0]);
    assign unused_bits = ^{status[0], instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .funct3     (instr[14:12]),
        .funct7_b30 (instr[30]),
        .op_class   (op_class),
        .aluop      (aluop_dec)
    );

    always_comb begin
        branch_taken = 1'b0;
        case (instr[14:12])
            3'b000: branch_taken = status[ST_Z];
            3'b001: branch_taken = ~status[ST_Z];
            3'b100: branch_taken = status[ST_N] ^ status[ST_V];
            3'b101: branch_taken = ~(status[ST_N] ^ status[ST_V]);
            3'b110: branch_taken = ~status[ST_C];
            3'b111: branch_taken = status[ST_C];
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        ctrl_d             = '0;
        ctrl_d.aluop       = aluop_dec;
        ctrl_d.immgen_ctrl = IMM_NONE;
        case (op_class)
            CLS_R: begin
                ctrl_d.regrw = 1'b1;
            end
            CLS_IMM: begin
                ctrl_d.alusrc      = 1'b1;
                ctrl_d.regrw       = 1'b1;
                ctrl_d.immgen_ctrl = IMM_I;
            end
            CLS_LOAD: begin
                ctrl_d.alusrc      = 1'b1;
                ctrl_d.regrw       = 1'b1;
                ctrl_d.wb          = 1'b1;
                ctrl_d.immgen_ctrl = IMM_I;
            end
            CLS_STORE: begin
                ctrl_d.alusrc      = 1'b1;
                ctrl_d.memrw       = 1'b1;
                ctrl_d.immgen_ctrl = IMM_S;
            end
            CLS_BRANCH: begin
                ctrl_d.pcsrc       = branch_taken;
                ctrl_d.immgen_ctrl = IMM_B;
            end
            default: begin
                ctrl_d.aluop = ALU_ADD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign pcsrc       = ctrl_q.pcsrc;
    assign alusrc      = ctrl_q.alusrc;
    assign aluop       = ctrl_q.aluop;
    assign memrw       = ctrl_q.memrw;
    assign wb          = ctrl_q.wb;
    assign regrw       = ctrl_q.regrw;
    assign immgen_ctrl = ctrl_q.immgen_ctrl;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a vector table of instr/status with
// hand-computed control bundles, plus reset sequences.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  status;
    logic [31:0] instr;
    logic        pcsrc;
    logic        alusrc;
    logic [3:0]  aluop;
    logic        memrw;
    logic        wb;
    logic        regrw;
    logic [1:0]  immgen_ctrl;

    int n_cmp;
    int n_bad;

    // packed as {pcsrc, alusrc, aluop[3:0], memrw, wb, regrw, immgen_ctrl[1:0]}
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  status;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    control_unit dut (
        .clk         (clk),
        .rst         (rst_n),
        .status      (status),
        .instr       (instr),
        .pcsrc       (pcsrc),
        .alusrc      (alusrc),
        .aluop       (aluop),
        .memrw       (memrw),
        .wb          (wb),
        .regrw       (regrw),
        .immgen_ctrl (immgen_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {pcsrc, alusrc, aluop, memrw, wb, regrw, immgen_ctrl};
    endfunction

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = outs();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got p=%b a=%b op=%b m=%b w=%b r=%b imm=%b, want p=%b a=%b op=%b m=%b w=%b r=%b imm=%b",
                     name, act[10], act[9], act[8:5], act[4], act[3], act[2], act[1:0],
                     exp[10], exp[9], exp[8:5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    task automatic add_vec(input string name, input logic [31:0] i, input logic [4:0] s,
                           input logic [10:0] e);
        vec_t v;
        v.name   = name;
        v.instr  = i;
        v.status = s;
        v.exp    = e;
        vecs.push_back(v);
    endtask

    localparam logic [10:0] E_NOP = 11'b0_0_0000_0_0_0_11;
    localparam logic [10:0] E_ADD = 11'b0_0_0000_0_0_1_11;
    localparam logic [10:0] E_SW  = 11'b0_1_0000_1_0_0_01;

    logic [10:0] prev_exp;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b1;
        instr  = 32'h0073_02B3;
        status = 5'b00000;

        add_vec("nop_zero",   32'h0000_0000, 5'b00000, E_NOP);
        add_vec("r_add",      32'h0073_02B3, 5'b00000, E_ADD);
        add_vec("r_add_z",    32'h0073_02B3, 5'b10000, E_ADD);
        add_vec("r_sub",      32'h4073_02B3, 5'b00000, 11'b0_0_0001_0_0_1_11);
        add_vec("r_sll",      32'h0073_12B3, 5'b00000, 11'b0_0_0010_0_0_1_11);
        add_vec("r_slt",      32'h0073_22B3, 5'b00000, 11'b0_0_0011_0_0_1_11);
        add_vec("r_sltu",     32'h0073_32B3, 5'b00000, 11'b0_0_0100_0_0_1_11);
        add_vec("r_xor",      32'h0073_42B3, 5'b00000, 11'b0_0_0101_0_0_1_11);
        add_vec("r_srl",      32'h0073_52B3, 5'b00000, 11'b0_0_0110_0_0_1_11);
        add_vec("r_sra",      32'h4073_52B3, 5'b00000, 11'b0_0_0111_0_0_1_11);
        add_vec("r_or",       32'h0073_62B3, 5'b00000, 11'b0_0_1000_0_0_1_11);
        add_vec("r_and",      32'h0073_72B3, 5'b00000, 11'b0_0_1001_0_0_1_11);
        add_vec("addi",       32'h00A2_8393, 5'b00000, 11'b0_1_0000_0_0_1_00);
        add_vec("addi_b30",   32'h40A2_8393, 5'b00000, 11'b0_1_0000_0_0_1_00);
        add_vec("slti",       32'h00A2_A393, 5'b00000, 11'b0_1_0011_0_0_1_00);
        add_vec("srli",       32'h00A2_D393, 5'b00000, 11'b0_1_0110_0_0_1_00);
        add_vec("srai",       32'h40A2_D393, 5'b00000, 11'b0_1_0111_0_0_1_00);
        add_vec("sw",         32'h0063_A023, 5'b00000, E_SW);
        add_vec("lw",         32'h0003_AE03, 5'b00000, 11'b0_1_0000_0_1_1_00);
        add_vec("beq_z1",     32'h01C3_8F63, 5'b10000, 11'b1_0_0001_0_0_0_10);
        add_vec("beq_z0",     32'h01C3_8F63, 5'b00000, 11'b0_0_0001_0_0_0_10);
        add_vec("beq_rsvd",   32'h01C3_8F63, 5'b00001, 11'b0_0_0001_0_0_0_10);
        add_vec("bne_z0",     32'h01C3_9F63, 5'b00000, 11'b1_0_0001_0_0_0_10);
        add_vec("bne_z1",     32'h01C3_9F63, 5'b10000, 11'b0_0_0001_0_0_0_10);
        add_vec("blt_n1v0",   32'h01C3_CF63, 5'b01000, 11'b1_0_0001_0_0_0_10);
        add_vec("blt_n1v1",   32'h01C3_CF63, 5'b01010, 11'b0_0_0001_0_0_0_10);
        add_vec("bge_n1v1",   32'h01C3_DF63, 5'b01010, 11'b1_0_0001_0_0_0_10);
        add_vec("bge_n0v1",   32'h01C3_DF63, 5'b00010, 11'b0_0_0001_0_0_0_10);
        add_vec("bltu_c0",    32'h01C3_EF63, 5'b00000, 11'b1_0_0001_0_0_0_10);
        add_vec("bltu_c1",    32'h01C3_EF63, 5'b00100, 11'b0_0_0001_0_0_0_10);
        add_vec("bgeu_c0",    32'h01C3_FF63, 5'b00000, 11'b0_0_0001_0_0_0_10);
        add_vec("bgeu_c1",    32'h01C3_FF63, 5'b00100, 11'b1_0_0001_0_0_0_10);
        add_vec("br_f3_010",  32'h01C3_AF63, 5'b11111, 11'b0_0_0001_0_0_0_10);
        add_vec("br_f3_011",  32'h01C3_BF63, 5'b11111, 11'b0_0_0001_0_0_0_10);
        add_vec("jal_nop",    32'h0000_006F, 5'b11111, E_NOP);
        add_vec("r_add_st",   32'h0073_02B3, 5'b11111, E_ADD);

        // asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check("reset_async_initial", 11'd0);
        @(posedge clk);
        #1 check("reset_held_edge", 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        instr = 32'h0000_0000;
        #1 check("reset_release_before_edge", 11'd0);
        @(posedge clk);
        #1 check("nop_after_release", E_NOP);
        prev_exp = E_NOP;

        foreach (vecs[k]) begin
            instr  = vecs[k].instr;
            status = vecs[k].status;
            @(negedge clk);
            check({vecs[k].name, "_hold"}, prev_exp);
            @(posedge clk);
            #1 check(vecs[k].name, vecs[k].exp);
            prev_exp = vecs[k].exp;
        end

        // reset mid-operation clears without a clock edge, and holds across edges
        instr  = 32'h0073_02B3;
        status = 5'b00000;
        @(posedge clk);
        #1 check("mid_load_add", E_ADD);
        #2 rst_n = 1'b0;
        #1 check("mid_reset_async", 11'd0);
        @(posedge clk);
        #1 check("mid_reset_held", 11'd0);
        instr = 32'h0063_A023;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_release_before_edge", 11'd0);
        @(posedge clk);
        #1 check("mid_release_sw", E_SW);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for the RV32I-subset datapath. Decodes the current 32-bit instruction and the 5-bit ALU status flags into datapath controls: PC source, ALU operand source, ALU operation, memory write, writeback select, register-file write and immediate-generator format.
- All outputs are registered. They sit between the instruction fetch stage and the execute/memory/writeback datapath.

Parameters:
- none (all encodings are fixed constants in the shared package)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low
- status  in  5  ALU flags: [4]=Z zero, [3]=N negative, [2]=C carry/no-borrow, [1]=V overflow, [0]=reserved (ignored)
- instr  in  32  current instruction; opcode=[6:0], funct3=[14:12], funct7 bit=[30]
- pcsrc  out  1  1 = take branch target, 0 = PC+4
- alusrc  out  1  1 = ALU operand B from immediate, 0 = from rs2
- aluop  out  4  ALU operation code
- memrw  out  1  1 = data-memory write (store), 0 = read/idle
- wb  out  1  writeback select: 1 = memory data, 0 = ALU result
- regrw  out  1  register-file write enable
- immgen_ctrl  out  2  immediate format: 00 I, 01 S, 10 B, 11 none

Behaviour:
- Reset (rst=0, asynchronous): all outputs forced to 0 (aluop=0000 ADD, immgen_ctrl=00) and held while rst=0.
- Out of reset, each rising clk edge registers the combinational decode of the current instr and status. Latency is 1 cycle, with no handshake.
- aluop codes: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- R-type (0110011): alusrc=0, regrw=1, wb=0, memrw=0, pcsrc=0, immgen_ctrl=11. aluop comes from funct3:
  - 000: ADD if instr[30]=0, else SUB
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL if instr[30]=0, else SRA
  - 110: OR
  - 111: AND
- I-type ALU (0010011): alusrc=1, regrw=1, wb=0, memrw=0, pcsrc=0, immgen_ctrl=00. aluop uses the R-type funct3 mapping, except funct3=000 is always ADD (instr[30] ignored). SRAI is selected by instr[30] at funct3=101.
- Load (0000011): alusrc=1, aluop=ADD, regrw=1, wb=1, memrw=0, pcsrc=0, immgen_ctrl=00. funct3 is ignored.
- Store (0100011): alusrc=1, aluop=ADD, regrw=0, wb=0, memrw=1, pcsrc=0, immgen_ctrl=01.
- Branch (1100011): alusrc=0, aluop=SUB, regrw=0, memrw=0, wb=0, immgen_ctrl=10. pcsrc by funct3:
  - 000 BEQ: Z
  - 001 BNE: ~Z
  - 100 BLT: N^V
  - 101 BGE: ~(N^V)
  - 110 BLTU: ~C
  - 111 BGEU: C
  - 010, 011: 0
- Any other opcode (including all-zero): NOP. All control outputs are 0, aluop=ADD, immgen_ctrl=11. No register or memory write occurs.
- status affects only pcsrc, and only for branch opcodes. status[0] never affects any output.
- Simultaneous changes of instr and status: both are sampled on the same edge. There is no priority between them.
- Reset asserted mid-operation clears outputs immediately, without waiting for a clock edge. On release, the first rising edge loads the decode of the instr present then.

Decomposition:
- Package control_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH)
  - aluop localparams/enum (ALU_ADD..ALU_AND)
  - immgen_ctrl constants (IMM_I, IMM_S, IMM_B, IMM_NONE)
  - status bit index constants (ST_Z, ST_N, ST_C, ST_V)
- One natural sub-module, alu_decoder: (funct3, instr[30], opcode class) -> aluop, combinational.
- Top level holds opcode decode, branch-condition logic and the output register.

Test Plan:
- Reset: rst=0 with arbitrary instr -> all outputs 0 asynchronously (before any clk edge); rst=1 then instr=0x00000000 -> outputs stay NOP (immgen_ctrl=11) after the next edge.
- R-type ADD: instr=0x007302B3, status=00000 -> after next edge: regrw=1, alusrc=0, aluop=0000, wb=0, memrw=0, pcsrc=0, immgen_ctrl=11. Same with status=10000 -> unchanged outputs. instr=0x407302B3 (SUB) -> aluop=0001.
- ADDI: instr=0x00A28393 -> regrw=1, alusrc=1, aluop=0000, immgen_ctrl=00, memrw=0, wb=0.
- Store then load: instr=0x0063A023 (SW) -> memrw=1, regrw=0, alusrc=1, aluop=0000, immgen_ctrl=01. Then instr=0x0003AE03 (LW) -> memrw=0, regrw=1, wb=1, alusrc=1, immgen_ctrl=00.
- BEQ: instr=0x01C38F63 with status=10000 -> pcsrc=1, aluop=0001, alusrc=0, regrw=0, immgen_ctrl=10. With status=00000 -> pcsrc=0.
- Branch variants: BNE (funct3=001) with Z=0 -> pcsrc=1. BLT with N=1, V=0 -> 1. BGEU with C=0 -> 0. Each output changes only at the rising clk edge after the stimulus.
